// File: rtl/rule_window_filter_pkg.sv
// Shared types and helpers for the rule window filter.
// The window compare widens all operands by one bit beyond the widest
// field so that adding the prefix length never wraps.
package rule_window_pkg;

    localparam int NUM_LANES_D     = 4;
    localparam int IDX_W_D         = 11;
    localparam int POS_W_D         = 11;
    localparam int FIELD_W_D       = 12;
    localparam int PRELOAD_BYTES_D = 32;

    // Compare width: widest of position/field plus one guard bit
    localparam int CMP_W = ((POS_W_D > FIELD_W_D) ? POS_W_D : FIELD_W_D) + 1;

    // One table entry, stored as {depth, offset}
    typedef struct packed {
        logic [FIELD_W_D-1:0] depth;
        logic [FIELD_W_D-1:0] offset;
    } entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // True when pos lies in the rule window; in prefix mode the window is
    // shifted by preload and anything inside the prefix itself is accepted.
    function automatic logic window_accept(
        input logic [CMP_W-1:0] pos,
        input logic [CMP_W-1:0] offset,
        input logic [CMP_W-1:0] depth,
        input logic [CMP_W-1:0] preload,
        input logic             prefix
    );
        logic inWin;
        if (prefix) begin
            inWin = (pos <= preload) ||
                    ((pos >= (offset + preload)) && (pos <= (depth + preload)));
        end else begin
            inWin = (offset <= pos) && (pos <= depth);
        end
        return inWin;
    endfunction

endpackage

// File: rtl/rule_window_filter_table.sv
// Rule depth/offset table: NUM_PORTS registered read ports, one write port.
// A read and write to the same address in one cycle returns the old entry.
module rule_window_table #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 24
) (
    input  logic                                clk,
    input  logic                                i_we,
    input  logic [ADDR_W-1:0]                   i_waddr,
    input  logic [DATA_W-1:0]                   i_wdata,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    i_raddr,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0]                  r_mem [0:(1<<ADDR_W)-1];
    logic [NUM_PORTS-1:0][DATA_W-1:0]   r_rdata;

    // Non-blocking write and reads in the same block give read-first behaviour
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            r_rdata[k] <= r_mem[i_raddr[k]];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rule_window_filter.sv
// Multi-lane rule window filter: looks up each candidate rule index and
// forwards it only if the match position falls in that rule's window.
// After reset the table is cleared one entry per cycle before ready rises.
// Optional hit/drop counters: define RULE_WINDOW_HIT_CNT_EN.
module rule_window_filter
    import rule_window_pkg::*;
#(
    parameter int NUM_LANES     = NUM_LANES_D,
    parameter int IDX_W         = IDX_W_D,
    parameter int POS_W         = POS_W_D,
    parameter int FIELD_W       = FIELD_W_D,
    parameter int PRELOAD_BYTES = PRELOAD_BYTES_D
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LANES*IDX_W-1:0]   index_in,
    input  logic [NUM_LANES-1:0]         index_vld_in,
    input  logic [POS_W-1:0]             pos_in,
    input  logic                         prefix_mode,
    input  logic                         cfg_we,
    input  logic [IDX_W-1:0]             cfg_addr,
    input  logic [2*FIELD_W-1:0]         cfg_wdata,
    output logic                         ready,
    output logic [NUM_LANES*IDX_W-1:0]   index_out,
    output logic [NUM_LANES-1:0]         index_vld_out
`ifdef RULE_WINDOW_HIT_CNT_EN
    ,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  drop_cnt
`endif
);

    state_t                              r_state;
    state_t                              w_nextState;
    logic [IDX_W-1:0]                    r_initAddr;
    logic                                r_ready;
    logic                                w_tblWe;
    logic [IDX_W-1:0]                    w_tblAddr;
    logic [2*FIELD_W-1:0]                w_tblData;

    logic [NUM_LANES-1:0][IDX_W-1:0]     w_raddr;
    logic [NUM_LANES-1:0][2*FIELD_W-1:0] w_rdData;

    logic [NUM_LANES-1:0]                r_s1Vld;
    logic [NUM_LANES*IDX_W-1:0]          r_s1Idx;
    logic [POS_W-1:0]                    r_s1Pos;
    logic                                r_s1Prefix;

    logic [NUM_LANES-1:0]                w_candidate;
    logic [NUM_LANES-1:0]                w_accept;
    logic [NUM_LANES*IDX_W-1:0]          w_outIdx;

    logic [NUM_LANES*IDX_W-1:0]          r_indexOut;
    logic [NUM_LANES-1:0]                r_vldOut;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Clear-address counter walks the whole table during INIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_initAddr <= '0;
        end else if (r_state == INIT) begin
            r_initAddr <= r_initAddr + IDX_W'(1);
        end
    end

    // Next state and table write-port steering (clear writes in INIT, cfg in RUN)
    always_comb begin
        w_nextState = r_state;
        w_tblWe     = 1'b0;
        w_tblAddr   = cfg_addr;
        w_tblData   = cfg_wdata;
        case (r_state)
            INIT: begin
                w_tblWe   = 1'b1;
                w_tblAddr = r_initAddr;
                w_tblData = '0;
                if (r_initAddr == '1) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_tblWe = cfg_we;
            end
            default: begin
                w_nextState = INIT;
            end
        endcase
    end

    // Ready rises on the same edge that enters RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_nextState == RUN);
        end
    end

    rule_window_table #(
        .NUM_PORTS (NUM_LANES),
        .ADDR_W    (IDX_W),
        .DATA_W    (2*FIELD_W)
    ) u_table (
        .clk     (clk),
        .i_we    (w_tblWe),
        .i_waddr (w_tblAddr),
        .i_wdata (w_tblData),
        .i_raddr (w_raddr),
        .o_rdata (w_rdData)
    );

    // Stage 1: carry lane qualifiers and match context alongside the table read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Vld <= '0;
        end else begin
            r_s1Vld <= (r_state == RUN) ? index_vld_in : '0;
        end
        r_s1Idx    <= index_in;
        r_s1Pos    <= pos_in;
        r_s1Prefix <= prefix_mode;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        entry_t           w_ent;
        logic [IDX_W-1:0] w_idx;

        assign w_raddr[k]  = index_in[k*IDX_W +: IDX_W];
        assign w_ent       = w_rdData[k];
        assign w_idx       = r_s1Idx[k*IDX_W +: IDX_W];
        assign w_candidate[k] = r_s1Vld[k] && (w_idx != '0);
        assign w_accept[k] = w_candidate[k] &&
                             window_accept(CMP_W'(r_s1Pos),
                                           CMP_W'(w_ent.offset),
                                           CMP_W'(w_ent.depth),
                                           CMP_W'(PRELOAD_BYTES),
                                           r_s1Prefix);
        assign w_outIdx[k*IDX_W +: IDX_W] = w_accept[k] ? w_idx : '0;
    end

    // Stage 2: register per-lane results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_indexOut <= '0;
            r_vldOut   <= '0;
        end else begin
            r_indexOut <= w_outIdx;
            r_vldOut   <= w_accept;
        end
    end

    assign ready         = r_ready;
    assign index_out     = r_indexOut;
    assign index_vld_out = r_vldOut;

`ifdef RULE_WINDOW_HIT_CNT_EN
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    logic [CNT_W-1:0] w_hitPop;
    logic [CNT_W-1:0] w_dropPop;
    logic [32:0]      w_hitSum;
    logic [32:0]      w_dropSum;
    logic [31:0]      r_hitCnt;
    logic [31:0]      r_dropCnt;

    // Count accepted lanes and evaluated-but-rejected lanes this cycle
    always_comb begin
        w_hitPop  = '0;
        w_dropPop = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_hitPop  = w_hitPop  + CNT_W'(w_accept[k]);
            w_dropPop = w_dropPop + CNT_W'(w_candidate[k] & ~w_accept[k]);
        end
    end

    assign w_hitSum  = {1'b0, r_hitCnt}  + 33'(w_hitPop);
    assign w_dropSum = {1'b0, r_dropCnt} + 33'(w_dropPop);

    // Saturating counters, updated alongside the output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hitCnt  <= '0;
            r_dropCnt <= '0;
        end else begin
            r_hitCnt  <= w_hitSum[32]  ? '1 : w_hitSum[31:0];
            r_dropCnt <= w_dropSum[32] ? '1 : w_dropSum[31:0];
        end
    end

    assign hit_cnt  = r_hitCnt;
    assign drop_cnt = r_dropCnt;
`endif

endmodule

// File: tb/tb_rule_window_filter.sv
// Testbench for rule_window_filter: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a simple model.
module tb_rule_window_filter;

    localparam int NL    = 4;
    localparam int IW    = 11;
    localparam int PW    = 11;
    localparam int FW    = 12;
    localparam int PB    = 32;
    localparam int DEPTH = 1 << IW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL*IW-1:0]  index_in;
    logic [NL-1:0]     index_vld_in;
    logic [PW-1:0]     pos_in;
    logic              prefix_mode;
    logic              cfg_we;
    logic [IW-1:0]     cfg_addr;
    logic [2*FW-1:0]   cfg_wdata;
    logic              ready;
    logic [NL*IW-1:0]  index_out;
    logic [NL-1:0]     index_vld_out;
`ifdef RULE_WINDOW_HIT_CNT_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       drop_cnt;
`endif

    always #5 clk = ~clk;

    rule_window_filter #(
        .NUM_LANES     (NL),
        .IDX_W         (IW),
        .POS_W         (PW),
        .FIELD_W       (FW),
        .PRELOAD_BYTES (PB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .index_in      (index_in),
        .index_vld_in  (index_vld_in),
        .pos_in        (pos_in),
        .prefix_mode   (prefix_mode),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .ready         (ready),
        .index_out     (index_out),
        .index_vld_out (index_vld_out)
`ifdef RULE_WINDOW_HIT_CNT_EN
        ,
        .hit_cnt       (hit_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: rule table as plain integers, results queued by input cycle
    int     mDepth [DEPTH];
    int     mOff   [DEPTH];
    longint mHit;
    longint mDrop;

    typedef struct {
        logic [NL*IW-1:0] idx;
        logic [NL-1:0]    vld;
        int               hits;
        int               drops;
    } exp_t;

    exp_t expQ[$];
    exp_t lastExp;

    typedef struct {
        logic [NL*IW-1:0] idx;
        logic [NL-1:0]    vld;
        int               pos;
        bit               pfx;
        logic [NL*IW-1:0] expIdx;
        logic [NL-1:0]    expVld;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [NL*IW-1:0] lanes(input int a0, input int a1, input int a2, input int a3);
        logic [IW-1:0] b0, b1, b2, b3;
        b0 = IW'(a0); b1 = IW'(a1); b2 = IW'(a2); b3 = IW'(a3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic bit inWindow(input int pos, input int off, input int dep, input bit pfx);
        if (pfx) return (pos <= PB) || (pos >= off + PB && pos <= dep + PB);
        return (pos >= off) && (pos <= dep);
    endfunction

    function automatic vec_t mkVec(input logic [NL*IW-1:0] idx, input logic [NL-1:0] vld,
                                   input int pos, input bit pfx,
                                   input logic [NL*IW-1:0] expIdx, input logic [NL-1:0] expVld);
        vec_t v;
        v.idx = idx; v.vld = vld; v.pos = pos; v.pfx = pfx;
        v.expIdx = expIdx; v.expVld = expVld;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, model it, advance to the next negedge
    task automatic applyStimulus(input logic [NL*IW-1:0] idx, input logic [NL-1:0] vld,
                                 input int pos, input bit pfx,
                                 input bit we, input int waddr, input int wdep, input int woff);
        exp_t e;
        index_in     = idx;
        index_vld_in = vld;
        pos_in       = PW'(pos);
        prefix_mode  = pfx;
        cfg_we       = we;
        cfg_addr     = IW'(waddr);
        cfg_wdata    = {FW'(wdep), FW'(woff)};
        e.idx = '0; e.vld = '0; e.hits = 0; e.drops = 0;
        for (int k = 0; k < NL; k++) begin
            int li;
            li = int'(idx[k*IW +: IW]);
            if (vld[k] && li != 0) begin
                if (inWindow(pos, mOff[li], mDepth[li], pfx)) begin
                    e.idx[k*IW +: IW] = IW'(li);
                    e.vld[k] = 1'b1;
                    e.hits++;
                end else begin
                    e.drops++;
                end
            end
        end
        expQ.push_back(e);
        if (we) begin
            mDepth[waddr] = wdep;
            mOff[waddr]   = woff;
        end
        @(negedge clk);
        if (expQ.size() == 2) begin
            lastExp = expQ.pop_front();
            mHit  += lastExp.hits;
            mDrop += lastExp.drops;
        end
    endtask

    task automatic idle();
        applyStimulus('0, '0, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_idx"}, index_out, lastExp.idx);
        checkOutput({tag, "_vld"}, index_vld_out, lastExp.vld);
`ifdef RULE_WINDOW_HIT_CNT_EN
        checkOutput({tag, "_hit"}, hit_cnt, 64'(mHit));
        checkOutput({tag, "_drop"}, drop_cnt, 64'(mDrop));
`endif
    endtask

    initial begin
        longint hitBase, dropBase;
        for (int a = 0; a < DEPTH; a++) begin
            mDepth[a] = 0;
            mOff[a]   = 0;
        end
        mHit = 0; mDrop = 0;
        lastExp.idx = '0; lastExp.vld = '0; lastExp.hits = 0; lastExp.drops = 0;

        reset = 1'b1; index_in = '0; index_vld_in = '0; pos_in = '0;
        prefix_mode = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Partway through INIT, pulse reset: INIT must restart from address 0
        repeat (500) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_vld", index_vld_out, 0);
        checkOutput("rst_idx", index_out, 0);
`ifdef RULE_WINDOW_HIT_CNT_EN
        checkOutput("rst_hit", hit_cnt, 0);
        checkOutput("rst_drop", drop_cnt, 0);
`endif
        reset = 1'b0;

        // Count edges to ready; probe that INIT ignores cfg writes and candidates
        for (int n = 1; n <= DEPTH; n++) begin
            @(posedge clk);
            #1;
            if (n == 1000) begin
                cfg_we = 1'b1; cfg_addr = IW'(5); cfg_wdata = {FW'(0), FW'(1)};
                index_in = lanes(5, 0, 0, 0); index_vld_in = 4'b0001; pos_in = '0;
            end
            if (n == 1001) begin
                cfg_we = 1'b0; index_vld_in = '0; index_in = '0;
            end
            if (n == 1002) checkOutput("init_drop_vld", index_vld_out, 0);
            if (n == 1) checkOutput("ready_n1", ready, 0);
            if (n == DEPTH - 1) checkOutput("ready_early", ready, 0);
            if (n == DEPTH) checkOutput("ready_rise", ready, 1);
        end
        @(negedge clk);
        expQ.delete();

        // Directed vectors; the first two run before any table write
        vecs.push_back(mkVec(lanes(5,0,0,0), 4'b0001, 0, 0, lanes(5,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(5,0,0,0), 4'b0001, 1, 0, lanes(0,0,0,0), 4'b0000));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 9, 0, lanes(0,0,0,0), 4'b0000));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 10, 0, lanes(100,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 40, 0, lanes(100,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 41, 0, lanes(0,0,0,0), 4'b0000));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 32, 1, lanes(100,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 41, 1, lanes(0,0,0,0), 4'b0000));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 42, 1, lanes(100,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 72, 1, lanes(100,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(100,0,0,0), 4'b0001, 73, 1, lanes(0,0,0,0), 4'b0000));
        vecs.push_back(mkVec(lanes(100,0,100,7), 4'b1011, 20, 0, lanes(100,0,0,0), 4'b0001));
        vecs.push_back(mkVec(lanes(100,100,100,100), 4'b1111, 20, 0, lanes(100,100,100,100), 4'b1111));
        vecs.push_back(mkVec(lanes(0,100,7,100), 4'b1111, 10, 0, lanes(0,100,0,100), 4'b1010));
        vecs.push_back(mkVec(lanes(0,0,0,7), 4'b1000, 10, 1, lanes(0,0,0,7), 4'b1000));
        vecs.push_back(mkVec(lanes(0,0,0,7), 4'b1000, 38, 1, lanes(0,0,0,0), 4'b0000));
        vecs.push_back(mkVec(lanes(0,9,0,0), 4'b0010, 2000, 1, lanes(0,9,0,0), 4'b0010));
        vecs.push_back(mkVec(lanes(9,0,0,0), 4'b0001, 2047, 0, lanes(9,0,0,0), 4'b0001));

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 2) begin
                applyStimulus('0, '0, 0, 0, 1'b1, 100, 40, 10);
                applyStimulus('0, '0, 0, 0, 1'b1, 7, 5, 6);
                applyStimulus('0, '0, 0, 0, 1'b1, 9, 4095, 0);
                idle();
            end
            applyStimulus(vecs[i].idx, vecs[i].vld, vecs[i].pos, vecs[i].pfx, 1'b0, 0, 0, 0);
            checkOutput($sformatf("vec%0d_lat1", i), index_vld_out, 0);
            idle();
            checkOutput($sformatf("vec%0d_idx", i), index_out, vecs[i].expIdx);
            checkOutput($sformatf("vec%0d_vld", i), index_vld_out, vecs[i].expVld);
        end

        // Four-lane vector back to back: one hit and one drop per cycle
        hitBase  = mHit;
        dropBase = mDrop;
        repeat (3) applyStimulus(lanes(100,0,100,7), 4'b1011, 20, 0, 1'b0, 0, 0, 0);
        idle();
        idle();
        checkOutput("burst_vld", index_vld_out, 0);
`ifdef RULE_WINDOW_HIT_CNT_EN
        checkOutput("burst_hit", hit_cnt, 64'(hitBase + 3));
        checkOutput("burst_drop", drop_cnt, 64'(dropBase + 3));
`endif

        // Write and lookup of the same entry in one cycle: lookup sees the old entry
        applyStimulus(lanes(100,0,0,0), 4'b0001, 20, 0, 1'b1, 100, 50, 45);
        applyStimulus(lanes(100,0,0,0), 4'b0001, 20, 0, 1'b0, 0, 0, 0);
        checkOutput("rdfirst_old_idx", index_out, lanes(100,0,0,0));
        checkOutput("rdfirst_old_vld", index_vld_out, 4'b0001);
        idle();
        checkOutput("rdfirst_new_vld", index_vld_out, 0);
        checkOutput("rdfirst_new_idx", index_out, 0);
        idle();

        // Randomized traffic checked every cycle against the model
        for (int c = 0; c < 400; c++) begin
            logic [NL*IW-1:0] ridx;
            logic [NL-1:0]    rvld;
            int rpos, waddr, wdep, woff;
            bit rpfx, rwe;
            for (int k = 0; k < NL; k++) begin
                int r;
                r = $urandom_range(0, 9);
                ridx[k*IW +: IW] = (r < 8) ? IW'(r) : IW'($urandom_range(0, DEPTH - 1));
            end
            rvld  = 4'($urandom_range(0, 15));
            rpos  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 110);
            rpfx  = 1'($urandom_range(0, 1));
            rwe   = ($urandom_range(0, 3) == 0);
            waddr = $urandom_range(0, 9);
            wdep  = ($urandom_range(0, 7) == 0) ? $urandom_range(4070, 4095) : $urandom_range(0, 100);
            woff  = $urandom_range(0, 100);
            applyStimulus(ridx, rvld, rpos, rpfx, rwe, waddr, wdep, woff);
            checkModel($sformatf("rand%0d", c));
        end
        idle();
        checkModel("drain0");
        idle();
        checkModel("drain1");

        // Reset while RUN with a result in flight clears everything
        applyStimulus(lanes(100,0,0,0), 4'b0001, 47, 0, 1'b0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("runrst_vld", index_vld_out, 0);
        checkOutput("runrst_idx", index_out, 0);
        checkOutput("runrst_ready", ready, 0);
`ifdef RULE_WINDOW_HIT_CNT_EN
        checkOutput("runrst_hit", hit_cnt, 0);
        checkOutput("runrst_drop", drop_cnt, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
